d_mem_request_queue: RTL and testbench

Buffers data-memory requests from the core and issues them in order to the data port of the single-cycle memory subsystem. It decouples core stores and loads from memory readiness, guarantees program-order issue, and returns read data to the core with a one-cycle response pulse. It sits directly upstream of the subsystem's `d_mem_*` port.

---
 rtl/d_mem_request_queue.sv | 172 +++++++++++++++++
 tb/tb_d_mem_request_queue.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/d_mem_request_queue.sv
// In-order request queue between the core and the data port of the memory subsystem.
// Stores issue back-to-back. A load blocks further issue until its tagged response returns.
module d_mem_request_queue #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 32,
  parameter int DEPTH        = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [DATA_WIDTH/8-1:0]   req_byte_en,
  input  logic [ADDRESS_BITS-1:0]   req_address,
  input  logic [DATA_WIDTH-1:0]     req_data,
  output logic                      resp_valid,
  output logic [DATA_WIDTH-1:0]     resp_data,
  output logic [ADDRESS_BITS-1:0]   resp_address,
  output logic                      d_mem_read,
  output logic                      d_mem_write,
  output logic [DATA_WIDTH/8-1:0]   d_mem_byte_en,
  output logic [ADDRESS_BITS-1:0]   d_mem_address_in,
  output logic [DATA_WIDTH-1:0]     d_mem_data_in,
  input  logic [DATA_WIDTH-1:0]     d_mem_data_out,
  input  logic [ADDRESS_BITS-1:0]   d_mem_address_out,
  input  logic                      d_mem_valid,
  input  logic                      d_mem_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int BE_W  = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_t;

  state_t state, state_next;

  logic                    q_write   [DEPTH];
  logic [BE_W-1:0]         q_byte_en [DEPTH];
  logic [ADDRESS_BITS-1:0] q_address [DEPTH];
  logic [DATA_WIDTH-1:0]   q_data    [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic read_match;

  logic                    read_next;
  logic                    write_next;
  logic [BE_W-1:0]         byte_en_next;
  logic [ADDRESS_BITS-1:0] address_next;
  logic [DATA_WIDTH-1:0]   data_next;
  logic                    resp_valid_next;
  logic [DATA_WIDTH-1:0]   resp_data_next;
  logic [ADDRESS_BITS-1:0] resp_address_next;

  assign full       = (count == (PTR_W+1)'(DEPTH));
  assign empty      = (count == '0);
  assign req_ready  = !full;
  assign push       = req_valid && !full;
  assign pop        = (state != RD) && !empty && d_mem_ready;
  assign read_match = (state == RD) && d_mem_valid && (d_mem_address_out == d_mem_address_in);

  // Entry storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (push) begin
      q_write[wr_ptr]   <= req_write;
      q_byte_en[wr_ptr] <= req_byte_en;
      q_address[wr_ptr] <= req_address;
      q_data[wr_ptr]    <= req_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue decision and registered memory-side / response values for the next edge.
  always_comb begin
    state_next        = state;
    read_next         = d_mem_read;
    write_next        = d_mem_write;
    byte_en_next      = d_mem_byte_en;
    address_next      = d_mem_address_in;
    data_next         = d_mem_data_in;
    resp_valid_next   = 1'b0;
    resp_data_next    = resp_data;
    resp_address_next = resp_address;

    case (state)
      IDLE, WR: begin
        if (pop) begin
          byte_en_next = q_byte_en[rd_ptr];
          address_next = q_address[rd_ptr];
          data_next    = q_data[rd_ptr];
          if (q_write[rd_ptr]) begin
            write_next = 1'b1;
            read_next  = 1'b0;
            state_next = WR;
          end else begin
            write_next = 1'b0;
            read_next  = 1'b1;
            state_next = RD;
          end
        end else begin
          write_next = 1'b0;
          read_next  = 1'b0;
          state_next = IDLE;
        end
      end
      RD: begin
        if (read_match) begin
          resp_valid_next   = 1'b1;
          resp_data_next    = d_mem_data_out;
          resp_address_next = d_mem_address_in;
          read_next         = 1'b0;
          state_next        = IDLE;
        end
      end
      default: begin
        write_next = 1'b0;
        read_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      d_mem_read       <= 1'b0;
      d_mem_write      <= 1'b0;
      d_mem_byte_en    <= '0;
      d_mem_address_in <= '0;
      d_mem_data_in    <= '0;
      resp_valid       <= 1'b0;
      resp_data        <= '0;
      resp_address     <= '0;
    end else begin
      state            <= state_next;
      d_mem_read       <= read_next;
      d_mem_write      <= write_next;
      d_mem_byte_en    <= byte_en_next;
      d_mem_address_in <= address_next;
      d_mem_data_in    <= data_next;
      resp_valid       <= resp_valid_next;
      resp_data        <= resp_data_next;
      resp_address     <= resp_address_next;
    end
  end

endmodule

// File: tb/tb_d_mem_request_queue.sv
// Directed bench for d_mem_request_queue: a queue-based reference model checked every cycle,
// plus literal expectations for the key latencies and data values.
module tb_d_mem_request_queue;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [3:0]  req_byte_en;
  logic [31:0] req_address;
  logic [31:0] req_data;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [31:0] resp_address;
  logic        d_mem_read;
  logic        d_mem_write;
  logic [3:0]  d_mem_byte_en;
  logic [31:0] d_mem_address_in;
  logic [31:0] d_mem_data_in;
  logic [31:0] d_mem_data_out;
  logic [31:0] d_mem_address_out;
  logic        d_mem_valid;
  logic        d_mem_ready;

  d_mem_request_queue #(.DATA_WIDTH(32), .ADDRESS_BITS(32), .DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_byte_en(req_byte_en), .req_address(req_address), .req_data(req_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_address(resp_address),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_byte_en(d_mem_byte_en),
    .d_mem_address_in(d_mem_address_in), .d_mem_data_in(d_mem_data_in),
    .d_mem_data_out(d_mem_data_out), .d_mem_address_out(d_mem_address_out),
    .d_mem_valid(d_mem_valid), .d_mem_ready(d_mem_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        w;
    logic [3:0]  be;
    logic [31:0] a;
    logic [31:0] d;
  } req_t;

  req_t        mq[$];
  logic        m_load_out, m_read, m_write, m_rvalid;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_data, m_rdata, m_raddr;

  logic [31:0] mem [int];
  logic [31:0] write_log[$];
  int          assertions = 0;
  int          failures = 0;
  int          resp_count = 0;
  int          read_count = 0;
  logic        auto_resp;
  logic        got;

  task automatic checkVal(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    m_load_out = 0; m_read = 0; m_write = 0; m_rvalid = 0;
    m_be = 0; m_addr = 0; m_data = 0; m_rdata = 0; m_raddr = 0;
  endtask

  // Predicts the effect of the coming clock edge from the currently applied inputs.
  task automatic modelUpdate();
    bit   can_push;
    req_t e;
    if (!reset) begin
      modelReset();
      return;
    end
    can_push = req_valid && (mq.size() < 4);
    m_rvalid = 0;
    if (m_load_out) begin
      if (d_mem_valid && d_mem_address_out == m_addr) begin
        m_rdata = d_mem_data_out; m_raddr = m_addr; m_rvalid = 1;
        m_read = 0; m_load_out = 0;
      end
    end else if (mq.size() > 0 && d_mem_ready) begin
      e = mq.pop_front();
      m_addr = e.a; m_be = e.be; m_data = e.d;
      m_write = e.w; m_read = !e.w; m_load_out = !e.w;
    end else begin
      m_write = 0; m_read = 0;
    end
    if (can_push) begin
      e.w = req_write; e.be = req_byte_en; e.a = req_address; e.d = req_data;
      mq.push_back(e);
    end
  endtask

  task automatic checkOutput();
    checkVal("req_ready", req_ready, mq.size() < 4);
    checkVal("resp_valid", resp_valid, m_rvalid);
    checkVal("resp_data", resp_data, m_rdata);
    checkVal("resp_address", resp_address, m_raddr);
    checkVal("d_mem_read", d_mem_read, m_read);
    checkVal("d_mem_write", d_mem_write, m_write);
    checkVal("d_mem_address_in", d_mem_address_in, m_addr);
    checkVal("d_mem_byte_en", d_mem_byte_en, m_be);
    checkVal("d_mem_data_in", d_mem_data_in, m_data);
  endtask

  // Memory stand-in: commits stores and answers loads one cycle after they appear.
  task automatic respond();
    logic [31:0] cur;
    if (d_mem_write) begin
      cur = mem.exists(d_mem_address_in) ? mem[d_mem_address_in] : 32'h0;
      for (int b = 0; b < 4; b++)
        if (d_mem_byte_en[b]) cur[b*8 +: 8] = d_mem_data_in[b*8 +: 8];
      mem[d_mem_address_in] = cur;
      write_log.push_back(d_mem_address_in);
    end
    if (d_mem_read) read_count++;
    if (auto_resp) begin
      if (d_mem_read) begin
        d_mem_valid = 1'b1;
        d_mem_address_out = d_mem_address_in;
        d_mem_data_out = mem.exists(d_mem_address_in) ? mem[d_mem_address_in] : 32'h0;
      end else begin
        d_mem_valid = 1'b0;
      end
    end
  endtask

  task automatic step();
    modelUpdate();
    @(posedge clock);
    @(negedge clock);
    checkOutput();
    if (resp_valid) resp_count++;
    respond();
  endtask

  task automatic applyStimulus(input logic v, input logic w, input logic [3:0] be,
                               input logic [31:0] a, input logic [31:0] d);
    req_valid = v; req_write = w; req_byte_en = be; req_address = a; req_data = d;
  endtask

  task automatic waitResp(input int max_cycles, output logic seen);
    seen = 0;
    for (int i = 0; i < max_cycles; i++) begin
      step();
      if (resp_valid) begin
        seen = 1;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; auto_resp = 1'b1; d_mem_ready = 1'b1;
    d_mem_valid = 1'b0; d_mem_address_out = '0; d_mem_data_out = '0;
    applyStimulus(0, 0, 4'h0, 32'h0, 32'h0);
    modelReset();
    #1 reset = 1'b0;

    // Reset held with a request pending
    applyStimulus(1, 1, 4'hF, 32'h100, 32'hDEADBEEF);
    step();
    step();
    checkVal("reset_req_ready", req_ready, 1);
    checkVal("reset_d_mem_write", d_mem_write, 0);
    checkVal("reset_d_mem_address_in", d_mem_address_in, 0);
    applyStimulus(0, 0, 4'h0, 32'h0, 32'h0);
    reset = 1'b1;
    step();
    checkVal("no_push_during_reset", d_mem_write, 0);
    applyStimulus(1, 1, 4'hF, 32'h0, 32'hA5A5A5A5);
    step();
    applyStimulus(0, 0, 4'h0, 32'h0, 32'h0);
    step();
    checkVal("first_store_write", d_mem_write, 1);
    checkVal("first_store_data", d_mem_data_in, 32'hA5A5A5A5);
    step();
    checkVal("first_store_one_cycle", d_mem_write, 0);

    // Store then load to address 4
    applyStimulus(1, 1, 4'hF, 32'h4, 32'h44444444);
    step();
    applyStimulus(0, 0, 4'h0, 32'h0, 32'h0);
    step();
    checkVal("st_write", d_mem_write, 1);
    checkVal("st_address", d_mem_address_in, 32'h4);
    step();
    checkVal("st_write_drop", d_mem_write, 0);
    applyStimulus(1, 0, 4'hF, 32'h4, 32'h0);
    step();
    applyStimulus(0, 0, 4'h0, 32'h0, 32'h0);
    step();
    checkVal("ld_read_n1", d_mem_read, 1);
    step();
    checkVal("ld_resp_valid", resp_valid, 1);
    checkVal("ld_resp_data", resp_data, 32'h44444444);
    checkVal("ld_resp_address", resp_address, 32'h4);
    step();
    checkVal("ld_resp_pulse", resp_valid, 0);

    // Fill with memory stalled, then drain
    d_mem_ready = 1'b0;
    write_log.delete();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 4'hF, 32'h10 + 32'(4*i), 32'hD0 + 32'(i));
      step();
    end
    checkVal("full_req_ready", req_ready, 0);
    applyStimulus(1, 1, 4'hF, 32'h50, 32'hBAD);
    step();
    checkVal("full_still_not_ready", req_ready, 0);
    applyStimulus(0, 0, 4'h0, 32'h0, 32'h0);
    d_mem_ready = 1'b1;
    step();
    checkVal("ready_after_pop", req_ready, 1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      checkVal("drain_write", d_mem_write, 1);
      checkVal("drain_address", d_mem_address_in, 32'h10 + 32'(4*i));
    end
    step();
    checkVal("drain_done", d_mem_write, 0);
    checkVal("drain_count", write_log.size(), 4);
    for (int i = 0; i < write_log.size(); i++)
      checkVal("drain_order", write_log[i], 32'h10 + 32'(4*i));

    // Store and load to the same address on back-to-back cycles
    applyStimulus(1, 1, 4'hF, 32'h4, 32'h12345678);
    step();
    applyStimulus(1, 0, 4'hF, 32'h4, 32'h0);
    step();
    applyStimulus(0, 0, 4'h0, 32'h0, 32'h0);
    waitResp(20, got);
    checkVal("order_resp_seen", got, 1);
    checkVal("order_resp_data", resp_data, 32'h12345678);
    checkVal("order_resp_address", resp_address, 32'h4);
    step();

    // Non-matching tag is ignored
    auto_resp = 1'b0;
    resp_count = 0;
    applyStimulus(1, 0, 4'hF, 32'h8, 32'h0);
    step();
    applyStimulus(0, 0, 4'h0, 32'h0, 32'h0);
    step();
    checkVal("tag_read_issued", d_mem_read, 1);
    d_mem_valid = 1'b1; d_mem_address_out = 32'h4; d_mem_data_out = 32'hBADBAD04;
    step();
    step();
    checkVal("tag_mismatch_no_resp", resp_valid, 0);
    checkVal("tag_mismatch_read_held", d_mem_read, 1);
    d_mem_address_out = 32'h8; d_mem_data_out = 32'hCAFE0008;
    step();
    checkVal("tag_match_resp", resp_valid, 1);
    checkVal("tag_match_data", resp_data, 32'hCAFE0008);
    d_mem_valid = 1'b0;
    step();
    step();
    checkVal("tag_resp_count", resp_count, 1);

    // Reset while a load is outstanding with two entries queued
    applyStimulus(1, 0, 4'hF, 32'h20, 32'h0);
    step();
    applyStimulus(1, 1, 4'hF, 32'h24, 32'h24242424);
    step();
    applyStimulus(1, 0, 4'hF, 32'h28, 32'h0);
    step();
    applyStimulus(0, 0, 4'h0, 32'h0, 32'h0);
    checkVal("midload_in_rd", d_mem_read, 1);
    reset = 1'b0;
    modelReset();
    #1;
    checkVal("midload_read_drop", d_mem_read, 0);
    checkOutput();
    step();
    step();
    reset = 1'b1;
    auto_resp = 1'b1;
    d_mem_valid = 1'b0;
    resp_count = 0;
    read_count = 0;
    write_log.delete();
    for (int i = 0; i < 5; i++) step();
    checkVal("midload_no_resp", resp_count, 0);
    checkVal("midload_no_reads", read_count, 0);
    checkVal("midload_no_writes", write_log.size(), 0);
    applyStimulus(1, 0, 4'hF, 32'h4, 32'h0);
    step();
    applyStimulus(0, 0, 4'h0, 32'h0, 32'h0);
    waitResp(20, got);
    checkVal("post_reset_resp_seen", got, 1);
    checkVal("post_reset_resp_data", resp_data, 32'h12345678);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
